// File: rtl/logic_unit_nbit.sv
// logic_unit_nbit: registered N-bit bitwise logic unit with a valid/ready
// handshake on both sides, an optional accumulator operand, result flags
// (zero, parity) and a saturating count of accepted operations.
module logic_unit_nbit #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             use_acc,
  input  logic             acc_wr,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             parity,
  output logic [WIDTH-1:0] acc,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_NOTA = 3'b011,
    OP_NAND = 3'b100,
    OP_NOR  = 3'b101,
    OP_XNOR = 3'b110,
    OP_PASS = 3'b111
  } op_e;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_y;
  logic             r_zero;
  logic             r_parity;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_op_count;

  logic             w_in_ready;
  logic             w_accept;
  logic [WIDTH-1:0] w_opa;
  logic [WIDTH-1:0] w_result;

  // A slot opens when the result register is empty or is being drained now;
  // this depends only on out_valid/out_ready, never on in_valid.
  assign w_in_ready = !r_out_valid || out_ready;
  assign w_accept   = in_valid && w_in_ready;
  // Operand A comes from the accumulator value held before this edge.
  assign w_opa      = use_acc ? r_acc : a;

  // Combinational operation decode.
  always_comb begin
    // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
    w_result = w_opa;
    unique case (op_e'(op))
      OP_AND:  w_result = w_opa & b;
      OP_OR:   w_result = w_opa | b;
      OP_XOR:  w_result = w_opa ^ b;
      OP_NOTA: w_result = ~w_opa;
      OP_NAND: w_result = ~(w_opa & b);
      OP_NOR:  w_result = ~(w_opa | b);
      OP_XNOR: w_result = ~(w_opa ^ b);
      OP_PASS: w_result = w_opa;
      default: w_result = w_opa;
    endcase
  end

  // Result register, flags and the out_valid (EMPTY/FULL) flag.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every register sample pre-edge values, avoiding ordering races.
    if (rst) begin
      r_out_valid <= 1'b0;
      r_y         <= '0;
      r_zero      <= 1'b1;
      r_parity    <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_y         <= w_result;
      r_zero      <= (w_result == '0);
      r_parity    <= ^w_result;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Accumulator: clear has priority over a write-back of the accepted result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
    end else if (acc_clr) begin
      r_acc <= '0;
    end else if (w_accept && acc_wr) begin
      r_acc <= w_result;
    end
  end

  // Saturating count of accepted operations.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op_count <= '0;
    end else if (w_accept && (r_op_count != '1)) begin
      r_op_count <= r_op_count + 1'b1;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign y         = r_y;
  assign zero      = r_zero;
  assign parity    = r_parity;
  assign acc       = r_acc;
  assign op_count  = r_op_count;

endmodule

// File: tb/tb_logic_unit_nbit.sv
// Bench for logic_unit_nbit: two instances (CNT_W=8 and CNT_W=2) share one
// stimulus stream; a cycle model checks both every cycle, and directed
// vectors pin the model with hand-computed literals.
module tb_logic_unit_nbit;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic [2:0] op;
  logic       use_acc;
  logic       acc_wr;
  logic       acc_clr;
  logic       out_ready;

  logic       in_ready,  in_ready2;
  logic       out_valid, out_valid2;
  logic [3:0] y,         y2;
  logic       zero,      zero2;
  logic       parity,    parity2;
  logic [3:0] acc,       acc2;
  logic [7:0] op_count;
  logic [1:0] op_count2;

  int n_tests = 0;
  int n_fail  = 0;

  logic_unit_nbit #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .use_acc(use_acc), .acc_wr(acc_wr),
    .acc_clr(acc_clr), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .zero(zero), .parity(parity), .acc(acc), .op_count(op_count)
  );

  logic_unit_nbit #(.WIDTH(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a), .b(b), .op(op), .use_acc(use_acc), .acc_wr(acc_wr),
    .acc_clr(acc_clr), .out_valid(out_valid2), .out_ready(out_ready),
    .y(y2), .zero(zero2), .parity(parity2), .acc(acc2), .op_count(op_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit         m_live = 0;
  bit         m_full;
  logic [3:0] m_y;
  logic [3:0] m_acc;
  int         m_accepts;

  function automatic logic [3:0] lu(input logic [2:0] o, input logic [3:0] x, input logic [3:0] z);
    logic [3:0] r;
    case (o)
      3'd0: r = x & z;
      3'd1: r = x | z;
      3'd2: r = x ^ z;
      3'd3: r = ~x;
      3'd4: r = ~(x & z);
      3'd5: r = ~(x | z);
      3'd6: r = ~(x ^ z);
      default: r = x;
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    logic       take;
    logic [3:0] res;
    if (rst) begin
      m_live    = 1;
      m_full    = 0;
      m_y       = 4'd0;
      m_acc     = 4'd0;
      m_accepts = 0;
    end else if (m_live) begin
      take = in_valid && (!m_full || out_ready);
      res  = lu(op, use_acc ? m_acc : a, b);
      if (acc_clr) m_acc = 4'd0;
      else if (take && acc_wr) m_acc = res;
      if (take) begin
        m_y = res;
        m_full = 1;
        m_accepts++;
      end else if (out_ready) begin
        m_full = 0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_live) begin
      check("cmp_out_valid", out_valid, m_full);
      check("cmp_y", y, m_y);
      check("cmp_zero", zero, m_y == 4'd0);
      check("cmp_parity", parity, $countones(m_y) % 2);
      check("cmp_acc", acc, m_acc);
      check("cmp_in_ready", in_ready, !m_full || out_ready);
      check("cmp_op_count", op_count, (m_accepts > 255) ? 255 : m_accepts);
      check("cmp_op_count2", op_count2, (m_accepts > 3) ? 3 : m_accepts);
      check("cmp_y2", y2, m_y);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input logic r, input logic v, input logic [3:0] ai, input logic [3:0] bi,
                      input logic [2:0] o, input logic ua, input logic aw, input logic ac,
                      input logic ordy);
    rst = r; in_valid = v; a = ai; b = bi; op = o;
    use_acc = ua; acc_wr = aw; acc_clr = ac; out_ready = ordy;
    @(posedge clk);
    #2;
  endtask

  logic [3:0] exp35 [8];

  initial begin
    exp35 = '{4'b1000, 4'b1110, 4'b0110, 4'b0011, 4'b0111, 4'b0001, 4'b1001, 4'b1100};
    rst = 1; in_valid = 0; a = 0; b = 0; op = 0;
    use_acc = 0; acc_wr = 0; acc_clr = 0; out_ready = 0;

    // Reset state, in_ready high during reset.
    step(1, 1, 4'hF, 4'hF, 3'd0, 0, 1, 0, 0);
    step(1, 0, 4'h0, 4'h0, 3'd0, 0, 0, 0, 0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_y", y, 4'h0);
    check("rst_zero", zero, 1'b1);
    check("rst_parity", parity, 1'b0);
    check("rst_acc", acc, 4'h0);
    check("rst_op_count", op_count, 8'd0);
    check("rst_in_ready", in_ready, 1'b1);

    // All eight ops back-to-back, one result per cycle.
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 4'b1100, 4'b1010, 3'(i), 0, 0, 0, 1);
      check($sformatf("op%0d_y", i), y, exp35[i]);
      check($sformatf("op%0d_valid", i), out_valid, 1'b1);
    end
    check("op_count_8", op_count, 8'd8);

    // Zero / parity flags.
    step(0, 1, 4'b0101, 4'b0101, 3'b010, 0, 0, 0, 1);
    check("flag_y0", y, 4'h0);
    check("flag_zero1", zero, 1'b1);
    check("flag_par0", parity, 1'b0);
    step(0, 1, 4'b0111, 4'b0000, 3'b111, 0, 0, 0, 1);
    check("flag_zero0", zero, 1'b0);
    check("flag_par1", parity, 1'b1);
    step(0, 0, 4'h0, 4'h0, 3'd0, 0, 0, 0, 1);
    check("drain_valid", out_valid, 1'b0);
    check("drain_y_hold", y, 4'b0111);

    // Backpressure: stall for 5 cycles, then drain and accept together.
    step(0, 1, 4'b1100, 4'b1010, 3'b000, 0, 0, 0, 0);
    check("bp_y", y, 4'b1000);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 4'b0011, 4'b0100, 3'b001, 0, 1, 0, 0);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_y_stable", y, 4'b1000);
      check("bp_valid", out_valid, 1'b1);
      check("bp_acc_ignored", acc, 4'h0);
    end
    step(0, 1, 4'b0011, 4'b0100, 3'b001, 0, 0, 0, 1);
    check("bp_new_y", y, 4'b0111);
    check("bp_valid_kept", out_valid, 1'b1);

    // Accumulator write, use, and clear-with-write priority.
    step(0, 1, 4'b0011, 4'b0000, 3'b111, 0, 1, 0, 1);
    check("acc_load", acc, 4'b0011);
    step(0, 1, 4'b1111, 4'b0101, 3'b010, 1, 1, 0, 1);
    check("acc_use_y", y, 4'b0110);
    check("acc_use", acc, 4'b0110);
    step(0, 1, 4'b1111, 4'b0000, 3'b111, 1, 1, 1, 1);
    check("acc_clr_pri", acc, 4'b0000);
    check("acc_clr_old_y", y, 4'b0110);
    step(0, 1, 4'b1001, 4'b0000, 3'b111, 0, 1, 0, 1);
    step(0, 0, 4'b1111, 4'b0000, 3'b111, 0, 1, 0, 1);
    check("acc_no_accept", acc, 4'b1001);
    step(0, 0, 4'b1111, 4'b0000, 3'b111, 0, 0, 1, 1);
    check("acc_clr_idle", acc, 4'b0000);

    // Reset while holding a result with acc=1111.
    step(0, 1, 4'b1111, 4'b0000, 3'b111, 0, 1, 0, 0);
    check("pre_rst_acc", acc, 4'b1111);
    step(1, 1, 4'b0001, 4'b0001, 3'b000, 0, 1, 0, 1);
    check("rst2_valid", out_valid, 1'b0);
    check("rst2_y", y, 4'h0);
    check("rst2_zero", zero, 1'b1);
    check("rst2_acc", acc, 4'h0);
    check("rst2_count", op_count, 8'd0);
    check("rst2_in_ready", in_ready, 1'b1);

    // Saturating counter with CNT_W=2.
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 4'h3, 4'h5, 3'(i), 0, 0, 0, 1);
      check($sformatf("sat_cnt2_%0d", i), op_count2, (i < 3) ? 2'(i + 1) : 2'd3);
      check($sformatf("sat_cnt8_%0d", i), op_count, 8'(i + 1));
    end

    // Mixed traffic checked by the model only.
    for (int i = 0; i < 60; i++) begin
      step(0, 1'($urandom), 4'($urandom), 4'($urandom), 3'($urandom),
           1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0), 1'($urandom));
    end

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/logic_unit_nbit.md
LOGIC_UNIT_NBIT -- requirements
Module: logic_unit_nbit

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4, setting the operand and result bit width (legal range 1..64).
REQ-002 The module SHALL have parameter CNT_W, default 8, setting the accepted-operation counter width (legal range 2..32).
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port in_valid, input, 1 bit: the operand/op fields are valid this cycle.
REQ-006 The module SHALL have port in_ready, output, 1 bit: the unit can accept this cycle.
REQ-007 The module SHALL have port a, input, WIDTH bits: operand A.
REQ-008 The module SHALL have port b, input, WIDTH bits: operand B.
REQ-009 The module SHALL have port op, input, 3 bits: operation select.
REQ-010 The module SHALL have port use_acc, input, 1 bit: substitute the accumulator for operand A.
REQ-011 The module SHALL have port acc_wr, input, 1 bit: load the accumulator with this operation's result.
REQ-012 The module SHALL have port acc_clr, input, 1 bit: clear the accumulator; sampled every cycle, independent of the handshake.
REQ-013 The module SHALL have port out_valid, output, 1 bit: the result register holds an undelivered result.
REQ-014 The module SHALL have port out_ready, input, 1 bit: the consumer accepts the result this cycle.
REQ-015 The module SHALL have port y, output, WIDTH bits: the registered result.
REQ-016 The module SHALL have port zero, output, 1 bit: registered flag, y == 0.
REQ-017 The module SHALL have port parity, output, 1 bit: registered XOR-reduction of y.
REQ-018 The module SHALL have port acc, output, WIDTH bits: the current accumulator value.
REQ-019 The module SHALL have port op_count, output, CNT_W bits: the saturating count of accepted operations.

Function
REQ-020 The module SHALL decode op bitwise over WIDTH bits as: 000 A&B, 001 A|B, 010 A^B, 011 ~A, 100 ~(A&B), 101 ~(A|B), 110 ~(A^B), 111 A (pass).
REQ-021 The module SHALL take operand A as acc when use_acc=1 and as a otherwise; the acc value used is the one held before the current edge.
REQ-022 The module SHALL drive in_ready = !out_valid || out_ready combinationally; no combinational path from in_valid to in_ready is permitted.
REQ-023 The module SHALL define an accept as in_valid && in_ready at a rising edge; on an accept, y, zero and parity load the new result and out_valid=1 on the next cycle (latency 1).
REQ-024 The module SHALL clear out_valid when out_valid && out_ready with no accept in the same cycle, and y SHALL hold its value.
REQ-025 The module SHALL, on a simultaneous accept and output drain, load the new result with out_valid remaining 1, giving full throughput of one operation per cycle.
REQ-026 The module SHALL hold y, zero, parity and out_valid stable while out_valid=1 and out_ready=0, with in_ready=0.
REQ-027 The module SHALL ignore op, a, b, use_acc and acc_wr on cycles without an accept.
REQ-028 The module SHALL load acc with the new result on an accept with acc_wr=1.
REQ-029 The module SHALL set acc to 0 whenever acc_clr=1, at any time, taking priority over acc_wr in the same cycle; the operation accepted in that same cycle still uses the old acc as operand A.
REQ-030 The module SHALL increment op_count by 1 on each accept, saturating at 2^CNT_W-1 with no wrap.
REQ-031 The module SHALL have no state machine beyond the out_valid flag: EMPTY (out_valid=0) goes to FULL on an accept; FULL goes to EMPTY on a drain without an accept; FULL stays FULL on a drain with an accept, or with no drain.

Reset
REQ-032 The module SHALL, while rst=1 at an edge, set out_valid=0, y=0, zero=1, parity=0, acc=0 and op_count=0.
REQ-033 The module SHALL treat an accept or drain coinciding with rst as not occurring; any in-flight result is discarded.
REQ-034 The module SHALL keep in_ready=1 during and immediately after reset, since out_valid=0.

Verification
REQ-035 A bench SHALL apply WIDTH=4, a=1100, b=1010, each op 000..111 back-to-back with out_ready=1 -> y = 1000, 1110, 0110, 0011, 0111, 0001, 1001, 1100, one per cycle, each 1 cycle after its accept.
REQ-036 A bench SHALL apply a=0101, b=0101, op=010 -> y=0000, zero=1, parity=0; then a=0111, op=111 -> zero=0, parity=1.
REQ-037 A bench SHALL hold out_ready=0 after one accept -> in_ready=0 and y stable for 5 cycles; then raise out_ready together with in_valid -> the new result loads and out_valid stays 1.
REQ-038 A bench SHALL set acc_wr=1 with a=0011, op=111, then use_acc=1, acc_wr=1, b=0101, op=010 -> acc=0011, then 0110; then acc_clr=1 with an acc_wr accept in the same cycle -> acc=0000, and y uses the old acc.
REQ-039 A bench SHALL apply CNT_W=2 with 5 accepts -> op_count = 1, 2, 3, 3, 3.
REQ-040 A bench SHALL assert rst while out_valid=1 with acc=1111 -> next cycle out_valid=0, y=0000, zero=1, acc=0000, op_count=0, in_ready=1.
